// File: rtl/yuv2rgb_osd.sv
// yuv2rgb_osd: OSD overlay blend followed by YUV -> RGB conversion.
// Four-stage clock-enabled pipeline:
//   stage 1: capture pixel, syncs and the addressed CLUT entry
//   stage 2: per-component alpha blend of pixel and CLUT colour
//   stage 3: signed colour-matrix products
//   stage 4: sum, round, clip, blank when pixel_en is low
// The CLUT is written on every clk edge (not gated by clk_en) and is
// cleared to all-transparent by reset.

module yuv2rgb_osd #(
  parameter int FULL_RANGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic [7:0]  y_in,
  input  logic [7:0]  u_in,
  input  logic [7:0]  v_in,
  input  logic [7:0]  osd_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        pixel_en_in,
  input  logic        osd_enable,
  input  logic        clut_wr_en,
  input  logic [3:0]  clut_wr_addr,
  input  logic [27:0] clut_wr_data,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        pixel_en_out
);

  // Colour-matrix constants. Studio range expands Y by 298/256 after
  // removing the 16 black offset; unscaled mode keeps Y as-is.
  localparam logic signed [19:0] Y_OFFSET = (FULL_RANGE != 0) ? 20'sd16  : 20'sd0;
  localparam logic signed [19:0] K_Y      = (FULL_RANGE != 0) ? 20'sd298 : 20'sd256;
  localparam logic signed [19:0] K_VR     = (FULL_RANGE != 0) ? 20'sd409 : 20'sd359;
  localparam logic signed [19:0] K_UG     = (FULL_RANGE != 0) ? 20'sd100 : 20'sd88;
  localparam logic signed [19:0] K_VG     = (FULL_RANGE != 0) ? 20'sd208 : 20'sd183;
  localparam logic signed [19:0] K_UB     = (FULL_RANGE != 0) ? 20'sd516 : 20'sd454;
  localparam logic signed [19:0] C_OFFSET = 20'sd128;
  localparam logic signed [19:0] ROUND    = 20'sd128;

  // ---------------------------------------------------------------
  // Colour look-up table: 16 entries of {Y, U, V, A}
  // ---------------------------------------------------------------
  logic [27:0] clut_mem [16];

  // CLUT write port; reset clears every entry and wins over a write
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        clut_mem[i] <= '0;
      end
    end else if (clut_wr_en) begin
      clut_mem[clut_wr_addr] <= clut_wr_data;
    end
  end

  // ---------------------------------------------------------------
  // Stage 1: capture pixel, syncs and the selected CLUT entry.
  // The entry is read in the same edge as any write, so a write to
  // the addressed entry is seen only by the following pixel.
  // ---------------------------------------------------------------
  logic [27:0]     clut_rd;
  logic            osd_transparent;
  logic [27:0]     s1_clut_next;
  logic [2:0][7:0] s1_pix_reg;
  logic [27:0]     s1_clut_reg;
  logic [2:0]      s1_sync_reg;

  assign clut_rd         = clut_mem[osd_in[3:0]];
  assign osd_transparent = (osd_in == 8'd0) || !osd_enable;
  assign s1_clut_next    = {clut_rd[27:4], osd_transparent ? 4'd0 : clut_rd[3:0]};

  // Stage 1 register: sync bits packed as {h_sync, v_sync, pixel_en}
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_pix_reg  <= '0;
      s1_clut_reg <= '0;
      s1_sync_reg <= '0;
    end else if (clk_en) begin
      s1_pix_reg  <= {y_in, u_in, v_in};
      s1_clut_reg <= s1_clut_next;
      s1_sync_reg <= {h_sync_in, v_sync_in, pixel_en_in};
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: alpha blend. A=15 maps to a weight of 16 so a fully
  // opaque entry replaces the pixel exactly; A=0 leaves it untouched.
  // Component index: 2 = Y, 1 = U, 0 = V (same order as the CLUT word).
  // ---------------------------------------------------------------
  logic [4:0]      blend_w;
  logic [2:0][7:0] s2_pix_next;
  logic [2:0][7:0] s2_pix_reg;
  logic [2:0]      s2_sync_reg;

  assign blend_w = (s1_clut_reg[3:0] == 4'hF) ? 5'd16 : {1'b0, s1_clut_reg[3:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_blend
      logic [11:0] keep_term;
      logic [11:0] ovl_term;
      logic [11:0] blend_sum;

      // Max 255*16 + 8 = 4088, so 12 bits never overflow
      assign keep_term   = {4'd0, s1_pix_reg[gi]} * {7'd0, 5'd16 - blend_w};
      assign ovl_term    = {4'd0, s1_clut_reg[4 + 8*gi +: 8]} * {7'd0, blend_w};
      assign blend_sum   = keep_term + ovl_term + 12'd8;
      assign s2_pix_next[gi] = 8'(blend_sum >> 4);
    end
  endgenerate

  // Stage 2 register: blended Y/U/V and delayed syncs
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_pix_reg  <= '0;
      s2_sync_reg <= '0;
    end else if (clk_en) begin
      s2_pix_reg  <= s2_pix_next;
      s2_sync_reg <= s1_sync_reg;
    end
  end

  // ---------------------------------------------------------------
  // Stage 3: signed products. Largest magnitude is 516*127 or
  // 298*239, both well inside 20-bit signed.
  // ---------------------------------------------------------------
  logic signed [19:0] y_s;
  logic signed [19:0] u_s;
  logic signed [19:0] v_s;
  logic signed [19:0] yterm_next;
  logic signed [19:0] vr_next;
  logic signed [19:0] ug_next;
  logic signed [19:0] vg_next;
  logic signed [19:0] ub_next;
  logic signed [19:0] s3_yterm_reg;
  logic signed [19:0] s3_vr_reg;
  logic signed [19:0] s3_ug_reg;
  logic signed [19:0] s3_vg_reg;
  logic signed [19:0] s3_ub_reg;
  logic [2:0]         s3_sync_reg;

  assign y_s = $signed({12'd0, s2_pix_reg[2]}) - Y_OFFSET;
  assign u_s = $signed({12'd0, s2_pix_reg[1]}) - C_OFFSET;
  assign v_s = $signed({12'd0, s2_pix_reg[0]}) - C_OFFSET;

  assign yterm_next = y_s * K_Y;
  assign vr_next    = v_s * K_VR;
  assign ug_next    = u_s * K_UG;
  assign vg_next    = v_s * K_VG;
  assign ub_next    = u_s * K_UB;

  // Stage 3 register: matrix products and delayed syncs
  always_ff @(posedge clk) begin
    if (!rst) begin
      s3_yterm_reg <= '0;
      s3_vr_reg    <= '0;
      s3_ug_reg    <= '0;
      s3_vg_reg    <= '0;
      s3_ub_reg    <= '0;
      s3_sync_reg  <= '0;
    end else if (clk_en) begin
      s3_yterm_reg <= yterm_next;
      s3_vr_reg    <= vr_next;
      s3_ug_reg    <= ug_next;
      s3_vg_reg    <= vg_next;
      s3_ub_reg    <= ub_next;
      s3_sync_reg  <= s2_sync_reg;
    end
  end

  // ---------------------------------------------------------------
  // Stage 4: sum, round, arithmetic shift and saturate to 0..255.
  // ---------------------------------------------------------------
  logic signed [19:0] r_sum;
  logic signed [19:0] g_sum;
  logic signed [19:0] b_sum;
  logic [7:0]         r_next;
  logic [7:0]         g_next;
  logic [7:0]         b_next;

  function automatic logic [7:0] clip8(input logic signed [19:0] s);
    logic signed [19:0] q;
    q = s >>> 8;
    if (q < 20'sd0) begin
      return 8'd0;
    end else if (q > 20'sd255) begin
      return 8'd255;
    end
    return 8'(q);
  endfunction

  assign r_sum = s3_yterm_reg + s3_vr_reg + ROUND;
  assign g_sum = s3_yterm_reg - s3_ug_reg - s3_vg_reg + ROUND;
  assign b_sum = s3_yterm_reg + s3_ub_reg + ROUND;

  assign r_next = clip8(r_sum);
  assign g_next = clip8(g_sum);
  assign b_next = clip8(b_sum);

  // Output register: RGB blanked to black outside the active area
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out        <= '0;
      g_out        <= '0;
      b_out        <= '0;
      h_sync_out   <= 1'b0;
      v_sync_out   <= 1'b0;
      pixel_en_out <= 1'b0;
    end else if (clk_en) begin
      r_out        <= s3_sync_reg[0] ? r_next : 8'd0;
      g_out        <= s3_sync_reg[0] ? g_next : 8'd0;
      b_out        <= s3_sync_reg[0] ? b_next : 8'd0;
      h_sync_out   <= s3_sync_reg[2];
      v_sync_out   <= s3_sync_reg[1];
      pixel_en_out <= s3_sync_reg[0];
    end
  end

endmodule
